// File: rtl/instr_prog_ctrl.sv
// Instruction-memory programming controller: parses an {address, length, payload} byte stream
// into little-endian instruction writes, holding the core halted while a load is in progress.
module instr_prog_ctrl #(
  parameter int unsigned PC_WIDTH    = 8,
  parameter int unsigned INSTR_WIDTH = 32,
  parameter int unsigned DEPTH       = 128
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   abort,
  output logic                   mem_we,
  output logic [PC_WIDTH-1:0]    mem_waddr,
  output logic [INSTR_WIDTH-1:0] mem_wdata,
  output logic                   halt,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int unsigned NBYTES = INSTR_WIDTH / 8;
  localparam int unsigned IdxW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NBYTES - 1);

  typedef enum logic [1:0] {StAddr, StLen, StData, StDone} state_e;

  state_e                 state_q, state_d;
  logic [PC_WIDTH-1:0]    addr_q, addr_d;
  logic [7:0]             cnt_q, cnt_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic [INSTR_WIDTH-1:0] shift_q, shift_d;
  logic                   mem_we_q, mem_we_d;
  logic [PC_WIDTH-1:0]    mem_waddr_q, mem_waddr_d;
  logic [INSTR_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                   in_ready_q, in_ready_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  logic accept;
  logic word_end;
  logic in_range;

  // Abort wins over a byte offered in the same cycle, so it also masks acceptance.
  assign accept   = in_valid && in_ready_q && !abort;
  assign word_end = accept && (state_q == StData) && (idx_q == LastIdx);
  assign in_range = (32'(addr_q) < DEPTH);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StAddr;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = StAddr;
    end else begin
      unique case (state_q)
        StAddr:  if (accept) state_d = StLen;
        StLen:   if (accept) state_d = (in_data == 8'd0) ? StDone : StData;
        StData:  if (word_end && (cnt_q == 8'd1)) state_d = StDone;
        StDone:  state_d = StAddr;
        default: state_d = StAddr;
      endcase
    end
  end

  // Datapath and registered-output next values
  always_comb begin
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    mem_we_d    = 1'b0;
    mem_waddr_d = mem_waddr_q;
    mem_wdata_d = mem_wdata_q;
    err_d       = err_q;

    if (accept) begin
      unique case (state_q)
        StAddr: begin
          addr_d = in_data[PC_WIDTH-1:0];
          err_d  = 1'b0;
        end
        StLen: begin
          cnt_d = in_data;
          idx_d = '0;
        end
        StData: begin
          shift_d[8*idx_q +: 8] = in_data;
          idx_d                 = idx_q + 1'b1;
          if (idx_q == LastIdx) begin
            idx_d       = '0;
            // Out-of-range words are latched but never strobed; they only flag err.
            mem_we_d    = in_range;
            mem_waddr_d = addr_q;
            mem_wdata_d = shift_d;
            err_d       = err_q | ~in_range;
            addr_d      = addr_q + 1'b1;
            cnt_d       = cnt_q - 1'b1;
          end
        end
        default: ;
      endcase
    end

    in_ready_d = (state_d != StDone);
    busy_d     = (state_d != StAddr);
    done_d     = (state_d == StDone);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q      <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_waddr_q <= '0;
      mem_wdata_q <= '0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      mem_we_q    <= mem_we_d;
      mem_waddr_q <= mem_waddr_d;
      mem_wdata_q <= mem_wdata_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_waddr = mem_waddr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign halt      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_instr_prog_ctrl.sv
// Bench for instr_prog_ctrl: table of loads, hand-written corner sequences (DONE overlap,
// abort, async reset) and randomized gapped loads checked against a transaction-level model.
module tb_instr_prog_ctrl;
  localparam int unsigned PcW   = 8;
  localparam int unsigned IW    = 32;
  localparam int unsigned Depth = 128;
  localparam int unsigned NB    = IW / 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [7:0]     in_data;
  logic           in_valid;
  logic           in_ready;
  logic           abort;
  logic           mem_we;
  logic [PcW-1:0] mem_waddr;
  logic [IW-1:0]  mem_wdata;
  logic           halt;
  logic           busy;
  logic           done;
  logic           err;

  instr_prog_ctrl #(
    .PC_WIDTH   (PcW),
    .INSTR_WIDTH(IW),
    .DEPTH      (Depth)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .abort    (abort),
    .mem_we   (mem_we),
    .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata),
    .halt     (halt),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [PcW+IW-1:0] act_q[$];
  logic [PcW+IW-1:0] exp_q[$];
  logic [IW-1:0]     words[$];
  int                done_cnt;
  int                we_done_cnt;
  int                halt_cyc;
  int                exp_we_done;
  bit                exp_err;

  typedef struct {
    logic [7:0]  addr;
    int          n;
    logic [31:0] w0;
    logic [31:0] w1;
    int          exp_writes;
    bit          exp_err;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Records what the memory port and status outputs did, cycle by cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_we) act_q.push_back({mem_waddr, mem_wdata});
      if (done) begin
        done_cnt++;
        if (mem_we) we_done_cnt++;
      end
      if (halt) halt_cyc++;
      check("halt_eq_busy", 64'(halt), 64'(busy));
    end
  end

  task automatic reset_queues();
    act_q.delete();
    exp_q.delete();
    done_cnt    = 0;
    we_done_cnt = 0;
    halt_cyc    = 0;
    exp_we_done = 0;
    exp_err     = 1'b0;
  endtask

  task automatic gen_words(input int n, input logic [31:0] w0, input logic [31:0] w1);
    words.delete();
    for (int i = 0; i < n; i++) begin
      if (i == 0) words.push_back(w0);
      else if (i == 1) words.push_back(w1);
      else words.push_back($urandom());
    end
  endtask

  // Reference: word i goes to (a + i) mod 2^PcW, written only when below Depth.
  task automatic model_load(input logic [7:0] a, input int n);
    int unsigned p;
    bit          last_in;
    exp_err = 1'b0;
    last_in = 1'b0;
    for (int i = 0; i < n; i++) begin
      p = (int'(a) + i) % (2 ** PcW);
      last_in = (p < Depth);
      if (last_in) exp_q.push_back({PcW'(p), words[i]});
      else exp_err = 1'b1;
    end
    if (n > 0 && last_in) exp_we_done++;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_pct);
    bit taken;
    taken = 1'b0;
    while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    for (int t = 0; t < 50 && !taken; t++) begin
      taken = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!taken) check("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_word(input logic [IW-1:0] w, input int nbytes, input int gap);
    for (int b = 0; b < nbytes; b++) send_byte(w[8*b +: 8], gap);
  endtask

  task automatic start_load(input logic [7:0] a, input int n, input int gap);
    send_byte(a, gap);
    check("err_clear_on_addr", 64'(err), 64'd0);
    send_byte(8'(n), gap);
    for (int i = 0; i < n; i++) send_word(words[i], NB, gap);
  endtask

  task automatic compare_writes(input string tag);
    check({tag, "_write_count"}, 64'(act_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < act_q.size()) check({tag, "_write"}, 64'(act_q[i]), 64'(exp_q[i]));
    end
  endtask

  task automatic finish_load(input int exp_done, input int exp_halt, input string tag);
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      if (done) seen = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    if (seen) begin
      check({tag, "_ready_low_in_done"}, 64'(in_ready), 64'd0);
      check({tag, "_halt_in_done"}, 64'(halt), 64'd1);
    end
    @(posedge clk); #1;
    check({tag, "_after_done_idle"}, 64'({halt, busy, done, in_ready}), 64'b0001);
    check({tag, "_err"}, 64'(err), 64'(exp_err));
    check({tag, "_done_count"}, 64'(done_cnt), 64'(exp_done));
    check({tag, "_write_with_done"}, 64'(we_done_cnt), 64'(exp_we_done));
    if (exp_halt >= 0) check({tag, "_halt_width"}, 64'(halt_cyc), 64'(exp_halt));
    compare_writes(tag);
  endtask

  task automatic run_load(input logic [7:0] a, input int n, input int gap, input bit chk_halt,
                          input string tag);
    reset_queues();
    model_load(a, n);
    start_load(a, n, gap);
    finish_load(1, chk_halt ? int'(2 + n * NB) : -1, tag);
  endtask

  // Sends a load but asserts abort together with byte ab of word aw.
  task automatic abort_case(input logic [7:0] a, input int n, input int aw, input int ab);
    reset_queues();
    gen_words(n, $urandom(), $urandom());
    model_load(a, aw);
    send_byte(a, 0);
    send_byte(8'(n), 0);
    for (int i = 0; i < aw; i++) send_word(words[i], NB, 0);
    send_word(words[aw], ab, 0);
    in_valid = 1'b1;
    in_data  = 8'hA5;
    abort    = 1'b1;
    @(posedge clk); #1;
    abort    = 1'b0;
    in_valid = 1'b0;
    check("abort_idle_next", 64'({halt, busy, done, in_ready}), 64'b0001);
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_done", 64'(done_cnt), 64'd0);
    check("abort_err_held", 64'(err), 64'(exp_err));
    compare_writes("abort");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'h05, 2, 32'h44332211, 32'hDDCCBBAA, 2, 1'b0};
    vecs[1] = '{8'h10, 0, 32'h0,        32'h0,        0, 1'b0};
    vecs[2] = '{8'h7F, 3, 32'h01020304, 32'h05060708, 1, 1'b1};
    vecs[3] = '{8'hFF, 2, 32'hCAFEF00D, 32'h12345678, 1, 1'b1};
    vecs[4] = '{8'h7E, 2, 32'h89ABCDEF, 32'hFEDCBA98, 2, 1'b0};
    vecs[5] = '{8'h00, 1, 32'h0BADBEEF, 32'h0,        1, 1'b0};
    vecs[6] = '{8'hFE, 3, 32'h11111111, 32'h22222222, 1, 1'b1};

    rst      = 1'b1;
    in_data  = 8'h00;
    in_valid = 1'b0;
    abort    = 1'b0;
    reset_queues();
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 64'({in_ready, mem_we, mem_waddr, mem_wdata, halt, busy, done, err}),
          64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("ready_after_reset", 64'({in_ready, halt, busy}), 64'b100);

    // Table of full-rate loads
    for (int v = 0; v < 7; v++) begin
      gen_words(vecs[v].n, vecs[v].w0, vecs[v].w1);
      run_load(vecs[v].addr, vecs[v].n, 0, 1'b1, "vec");
      check("vec_table_writes", 64'(act_q.size()), 64'(vecs[v].exp_writes));
      check("vec_table_err", 64'(err), 64'(vecs[v].exp_err));
      if (v == 0 && act_q.size() >= 2) begin
        check("basic_w0", 64'(act_q[0]), 64'({8'h05, 32'h44332211}));
        check("basic_w1", 64'(act_q[1]), 64'({8'h06, 32'hDDCCBBAA}));
      end
    end

    // Same basic stream with random gaps
    gen_words(2, 32'h44332211, 32'hDDCCBBAA);
    run_load(8'h05, 2, 40, 1'b0, "gapped");

    // Next header offered during DONE is taken the following cycle
    reset_queues();
    gen_words(2, 32'h44332211, 32'hDDCCBBAA);
    model_load(8'h05, 2);
    start_load(8'h05, 2, 0);
    check("overlap_done_now", 64'({done, in_ready}), 64'b10);
    gen_words(1, 32'h5A5AA5A5, 32'h0);
    model_load(8'h40, 1);
    start_load(8'h40, 1, 0);
    finish_load(2, -1, "overlap");

    // Aborts: mid word 2, right after a latched write, and with err already set
    abort_case(8'h20, 3, 1, 2);
    gen_words(2, $urandom(), $urandom());
    run_load(8'h21, 2, 0, 1'b1, "post_abort");
    abort_case(8'h7F, 3, 1, 0);
    abort_case(8'h80, 2, 1, 0);
    gen_words(1, $urandom(), $urandom());
    run_load(8'h33, 1, 0, 1'b1, "post_abort_err");

    // Asynchronous reset in the middle of DATA
    reset_queues();
    gen_words(2, 32'hA1B2C3D4, 32'h55667788);
    model_load(8'h30, 1);
    send_byte(8'h30, 0);
    send_byte(8'd2, 0);
    send_word(words[0], NB, 0);
    send_word(words[1], 1, 0);
    #2 rst = 1'b1;
    #1;
    check("async_rst_outputs",
          64'({in_ready, mem_we, mem_waddr, mem_wdata, halt, busy, done, err}), 64'd0);
    compare_writes("pre_rst");
    #8 rst = 1'b0;
    @(posedge clk); #1;
    check("ready_after_async_rst", 64'({in_ready, halt, busy}), 64'b100);
    gen_words(2, $urandom(), $urandom());
    run_load(8'h31, 2, 0, 1'b1, "post_rst");

    // Randomized gapped loads
    for (int r = 0; r < 25; r++) begin
      logic [7:0] a;
      int         n;
      a = 8'($urandom_range(255));
      n = int'($urandom_range(5));
      gen_words(n, $urandom(), $urandom());
      run_load(a, n, 30, 1'b0, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
